// File: rtl/conversor_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package conversor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned DEF_IN_W   = 13;
    localparam int unsigned DEF_DIGITS = 4;

    function automatic int unsigned cnt_width(input int unsigned in_w);
        return $clog2(in_w + 1);
    endfunction

    localparam int unsigned CNT_W = $clog2(DEF_IN_W + 1);

    // Double-dabble correction: any digit >= 5 gets +3 before the shift.
    localparam logic [3:0] BCD_THRESH = 4'd5;
    localparam logic [3:0] BCD_OFFSET = 4'd3;

endpackage

// File: rtl/corrector_bcd.sv
// Combinational "if >= 5 add 3" cell for one BCD digit.
module corrector_bcd
    import conversor_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] corrected
);

    always_comb begin
        corrected = (digit >= BCD_THRESH) ? digit + BCD_OFFSET : digit;
    end

endmodule

// File: rtl/conversor_bin_bcd.sv
// Sequential shift-and-add-3 binary to packed BCD converter, one input bit per clock.
// Optional CONVERSOR_ZERO_BLANK_EN adds a registered leading-zero blank_mask output.
module conversor_bin_bcd
    import conversor_pkg::*;
#(
    parameter int unsigned IN_W   = DEF_IN_W,
    parameter int unsigned DIGITS = DEF_DIGITS  // 10**DIGITS must exceed 2**IN_W - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
`ifdef CONVERSOR_ZERO_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank_mask
`endif
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CW    = cnt_width(IN_W);
    localparam int unsigned SW    = BCD_W + IN_W;

    state_t           state_q, state_d;
    logic [IN_W-1:0]  shreg_q, shreg_d;
    logic [BCD_W-1:0] scratch_q, scratch_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CW-1:0]    count_q, count_d;
    logic [BCD_W-1:0] corrected;
    logic [SW-1:0]    shifted;
    logic             last_shift;

    for (genvar i = 0; i < DIGITS; i++) begin : g_corr
        corrector_bcd u_corr (
            .digit     (scratch_q[4*i +: 4]),
            .corrected (corrected[4*i +: 4])
        );
    end

    always_comb begin
        shifted    = {corrected, shreg_q} << 1;
        last_shift = (state_q == SHIFT) && (count_q == CW'(IN_W - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            count_q   <= '0;
        end else begin
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        count_d   = count_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = bin_in;
                    scratch_d = '0;
                    count_d   = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shreg_d} = shifted;
                count_d              = count_q + 1'b1;
                // Publish only the fully shifted result, never intermediate scratch.
                if (last_shift) begin
                    bcd_d   = shifted[SW-1 -: BCD_W];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy    = (state_q == SHIFT);
        done    = (state_q == DONE);
        bcd_out = bcd_q;
    end

`ifdef CONVERSOR_ZERO_BLANK_EN
    logic [DIGITS-1:0] mask_q, mask_d;

    // Bit i set when digit i or any higher digit is nonzero; digit 0 always shown.
    function automatic logic [DIGITS-1:0] mask_of(input logic [BCD_W-1:0] v);
        logic [DIGITS-1:0] m;
        logic              any;
        any = 1'b0;
        m   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any  = any | (|v[4*i +: 4]);
            m[i] = any;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    always_comb begin
        mask_d = mask_q;
        if (last_shift) begin
            mask_d = mask_of(bcd_d);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q <= DIGITS'(1);
        end else begin
            mask_q <= mask_d;
        end
    end

    always_comb begin
        blank_mask = mask_q;
    end
`endif

endmodule
